// File: rtl/circular_dma_mm2s_fsm.sv
// circular_dma_mm2s_fsm
// ---------------------
// Drains a circular byte ring in memory onto an AXI-Stream master. The
// producer advances wr_ptr; this block issues AXI read bursts from
// mem_base+rd_ptr, forwards the returned beats to the stream and advances
// rd_ptr. Bursts never cross the ring end or a 4 KiB boundary.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              run request; dropping it stops after the current burst
//   clear_irq[1:0]      write-one-to-clear irq mask
//   enable_irq[1:0]     irq enable mask (bit0 stopped, bit1 read error)
//   irq[1:0]            bit0 stopped, bit1 read error
//   status_flags[1:0]   bit0 running, bit1 error
//   mem_base, mem_size  ring location/size, latched when leaving idle
//   wr_ptr              producer byte offset into the ring
//   rd_ptr              consumer byte offset into the ring
//   m_axi_*             AXI read address/data channels (master)
//   m_axis_mm2s_*       AXI-Stream output (master)
module circular_dma_mm2s_fsm #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_AXIS_WIDTH = 64,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              clear_irq,
    input  logic [1:0]              enable_irq,
    output logic [1:0]              irq,
    output logic [1:0]              status_flags,
    input  logic [C_ADDR_WIDTH-1:0] mem_base,
    input  logic [31:0]             mem_size,
    input  logic [31:0]             wr_ptr,
    output logic [31:0]             rd_ptr,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [C_AXIS_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [C_AXIS_WIDTH-1:0] m_axis_mm2s_tdata,
    output logic                    m_axis_mm2s_tlast,
    output logic                    m_axis_mm2s_tvalid,
    input  logic                    m_axis_mm2s_tready
);

    localparam int B     = C_AXIS_WIDTH / 8;      // bytes per beat
    localparam int BB    = C_MAX_BURST * B;       // bytes per max burst
    localparam int LOG2B = $clog2(B);
    // Clears the sub-beat bits of the producer pointer.
    localparam logic [31:0] BEAT_MASK = ~(32'(B) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_ADDR  = 2'd1,
        ST_DATA_BURST = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [1:0]              irq_d, status_d;
    logic [31:0]             rd_ptr_d;
    logic [C_ADDR_WIDTH-1:0] araddr_d;
    logic [7:0]              arlen_d;
    logic                    arvalid_d;
    logic                    err_burst, err_d;
    logic [C_ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]             size_q, size_d;

    // Only rresp[1] (SLVERR/DECERR) matters; OKAY vs EXOKAY is irrelevant.
    logic resp_unused;
    assign resp_unused = m_axi_rresp[0];

    // ------------------------------------------------------------------
    // Burst sizing
    // ------------------------------------------------------------------
    logic [31:0]             wp, avail, to_end, to_4k, beats;
    logic [C_ADDR_WIDTH-1:0] next_addr;
    logic                    ring_empty;

    always_comb begin
        wp         = wr_ptr & BEAT_MASK;
        next_addr  = base_q + C_ADDR_WIDTH'(rd_ptr);
        // An out-of-range producer pointer is treated as nothing to read.
        ring_empty = (wp == rd_ptr) || (wp >= size_q);
        avail      = (wp >= rd_ptr) ? (wp - rd_ptr) : (size_q - rd_ptr + wp);
        to_end     = size_q - rd_ptr;
        to_4k      = 32'd4096 - {20'd0, next_addr[11:0]};

        beats = 32'(C_MAX_BURST);
        if ((avail  >> LOG2B) < beats) beats = avail  >> LOG2B;
        if ((to_end >> LOG2B) < beats) beats = to_end >> LOG2B;
        if ((to_4k  >> LOG2B) < beats) beats = to_4k  >> LOG2B;
        if (ring_empty)                beats = '0;
    end

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    logic in_burst, err_any, r_hs;

    // The erroring beat itself must already be dropped, so the live rresp
    // is folded in alongside the sticky flag. Once in error, the R channel
    // is drained regardless of stream backpressure.
    assign in_burst           = (state == ST_DATA_BURST);
    assign err_any            = err_burst | (m_axi_rvalid & m_axi_rresp[1]);
    assign m_axis_mm2s_tdata  = m_axi_rdata;
    assign m_axis_mm2s_tvalid = in_burst & m_axi_rvalid & ~err_any;
    assign m_axis_mm2s_tlast  = in_burst & m_axi_rlast;
    assign m_axi_rready       = in_burst & (m_axis_mm2s_tready | err_any);
    assign r_hs               = m_axi_rvalid & m_axi_rready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        // Clear/mask every cycle; the set actions below override bits.
        irq_d     = irq & ~clear_irq & enable_irq;
        status_d  = status_flags;
        rd_ptr_d  = rd_ptr;
        araddr_d  = m_axi_araddr;
        arlen_d   = m_axi_arlen;
        arvalid_d = m_axi_arvalid;
        err_d     = err_burst;
        base_d    = base_q;
        size_d    = size_q;

        case (state)
            ST_IDLE: begin
                // Pending irqs block restart until software clears them.
                if (enable && irq == 2'b00 && mem_size >= 32'(BB)) begin
                    state_d  = ST_READ_ADDR;
                    rd_ptr_d = '0;
                    status_d = 2'b01;
                    base_d   = mem_base;
                    size_d   = mem_size;
                end
            end

            ST_READ_ADDR: begin
                if (m_axi_arvalid) begin
                    // Address/length stay frozen until accepted.
                    if (m_axi_arready) begin
                        arvalid_d = 1'b0;
                        state_d   = ST_DATA_BURST;
                    end
                end else if (!enable) begin
                    state_d     = ST_IDLE;
                    status_d[0] = 1'b0;
                    irq_d[0]    = enable_irq[0];
                end else if (beats != '0) begin
                    araddr_d  = next_addr;
                    arlen_d   = 8'(beats - 32'd1);
                    arvalid_d = 1'b1;
                end
            end

            ST_DATA_BURST: begin
                if (r_hs) begin
                    if (m_axi_rresp[1]) err_d = 1'b1;
                    if (m_axi_rlast) begin
                        if (err_d) begin
                            // Errored burst is not consumed: rd_ptr stays.
                            state_d  = ST_IDLE;
                            status_d = 2'b10;
                            irq_d[1] = enable_irq[1];
                            err_d    = 1'b0;
                        end else begin
                            rd_ptr_d = rd_ptr +
                                ((32'(m_axi_arlen) + 32'd1) << LOG2B);
                            if (rd_ptr_d == size_q) rd_ptr_d = '0;
                            state_d = ST_READ_ADDR;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            irq           <= '0;
            status_flags  <= '0;
            rd_ptr        <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            err_burst     <= 1'b0;
            base_q        <= '0;
            size_q        <= '0;
        end else begin
            state         <= state_d;
            irq           <= irq_d;
            status_flags  <= status_d;
            rd_ptr        <= rd_ptr_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arlen   <= arlen_d;
            m_axi_arvalid <= arvalid_d;
            err_burst     <= err_d;
            base_q        <= base_d;
            size_q        <= size_d;
        end
    end

endmodule
